// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage of the RISC-V core.
//
// Takes the EX/MEM register outputs and either passes the writeback fields
// straight through (no memory op) or runs a load/store as a sequence of
// single-byte transfers on a req/done handshake to the memory controller.
// Load bytes are assembled little-endian and sign/zero extended. While an
// access is in flight the stage requests a pipeline stall.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   mem_wdata_i         ALU result / writeback data from EX/MEM
//   mem_wd_i            destination register
//   mem_wreg_i          writeback enable
//   mem_me_op_i         00 none, 01 load, 10 store, 11 none
//   mem_me_addr_i       byte address of the access
//   mem_me_data_i       store data
//   mem_me_sel_i        00 byte, 01 half, 10/11 word
//   mem_me_extend_i     1 sign-extend, 0 zero-extend (loads)
//   wb_wdata_o/wd_o/wreg_o  writeback fields to MEM/WB
//   stallreq_o          stall request to pipeline control
//   mc_req_o            byte request to memory controller
//   mc_rw_o             1 write, 0 read
//   mc_addr_o           byte address
//   mc_wdata_o          write byte
//   mc_rdata_i          read byte, valid while mc_done_i=1
//   mc_done_i           one-cycle pulse per completed byte
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [4:0]        mem_wd_i,
    input  logic              mem_wreg_i,
    input  logic [1:0]        mem_me_op_i,
    input  logic [ADDR_W-1:0] mem_me_addr_i,
    input  logic [DATA_W-1:0] mem_me_data_i,
    input  logic [1:0]        mem_me_sel_i,
    input  logic              mem_me_extend_i,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [4:0]        wb_wd_o,
    output logic              wb_wreg_o,
    output logic              stallreq_o,
    output logic              mc_req_o,
    output logic              mc_rw_o,
    output logic [ADDR_W-1:0] mc_addr_o,
    output logic [7:0]        mc_wdata_o,
    input  logic [7:0]        mc_rdata_i,
    input  logic              mc_done_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic [1:0]        last_idx;
    logic [DATA_W-1:0] load_val;

    // Op / size decode. Op 11 behaves as none, size 11 behaves as word.
    always_comb begin
        is_load  = (mem_me_op_i == 2'b01);
        is_store = (mem_me_op_i == 2'b10);
        is_mem   = is_load | is_store;
        case (mem_me_sel_i)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // Load result: only the low N bytes of the buffer are used, so bytes left
    // over from an earlier wider access never leak into a narrower one.
    always_comb begin
        case (mem_me_sel_i)
            2'b00:   load_val = {{(DATA_W-8){mem_me_extend_i & buf_q[7]}}, buf_q[7:0]};
            2'b01:   load_val = {{(DATA_W-16){mem_me_extend_i & buf_q[15]}}, buf_q[15:0]};
            default: load_val = buf_q;
        endcase
    end

    // Next state and outputs. Everything is forced to 0 while rst is high,
    // including the purely combinational pass-through paths.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        wb_wdata_o = '0;
        wb_wd_o    = '0;
        wb_wreg_o  = 1'b0;
        stallreq_o = 1'b0;
        mc_req_o   = 1'b0;
        mc_rw_o    = 1'b0;
        mc_addr_o  = '0;
        mc_wdata_o = '0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    wb_wdata_o = mem_wdata_i;
                    wb_wd_o    = mem_wd_i;
                    wb_wreg_o  = mem_wreg_i;
                    if (is_mem) begin
                        // Hold the pipeline from the detect cycle onward so
                        // the instruction cannot retire before the access.
                        stallreq_o = 1'b1;
                        wb_wreg_o  = 1'b0;
                        cnt_d      = 2'd0;
                        buf_d      = '0;
                        state_d    = ACCESS;
                    end
                end

                ACCESS: begin
                    wb_wdata_o = mem_wdata_i;
                    wb_wd_o    = mem_wd_i;
                    stallreq_o = 1'b1;
                    mc_req_o   = 1'b1;
                    mc_rw_o    = is_store;
                    mc_addr_o  = mem_me_addr_i + ADDR_W'(cnt_q);
                    mc_wdata_o = mem_me_data_i[{cnt_q, 3'b000} +: 8];
                    if (mc_done_i) begin
                        if (is_load) begin
                            buf_d[{cnt_q, 3'b000} +: 8] = mc_rdata_i;
                        end
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == last_idx) begin
                            state_d = DONE;
                        end
                    end
                end

                DONE: begin
                    wb_wdata_o = is_load ? load_val : mem_wdata_i;
                    wb_wd_o    = mem_wd_i;
                    wb_wreg_o  = mem_wreg_i;
                    // Inputs seen at the next edge belong to the following
                    // instruction, so always go back through IDLE.
                    state_d    = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the RISC-V core. Consumes the EX/MEM register outputs: writeback fields, memory op, address, store data, access size and extend flag.
- Executes loads and stores over a byte-serial, req/done handshake to the memory controller.
- Assembles load data little-endian and applies sign or zero extension.
- Raises a stall request while an access is in flight and forwards the writeback fields to the MEM/WB register.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, register/data width (fixed 32; 4 bytes max per access)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_wdata_i  in  32  ALU result / writeback data from EX/MEM
- mem_wd_i  in  5  destination register
- mem_wreg_i  in  1  writeback enable
- mem_me_op_i  in  2  00 none, 01 load, 10 store, 11 treated as none
- mem_me_addr_i  in  32  byte address of access
- mem_me_data_i  in  32  store data
- mem_me_sel_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_me_extend_i  in  1  1 sign-extend, 0 zero-extend (loads only)
- wb_wdata_o  out  32  data to MEM/WB
- wb_wd_o  out  5  destination to MEM/WB
- wb_wreg_o  out  1  writeback enable to MEM/WB
- stallreq_o  out  1  stall request to pipeline control
- mc_req_o  out  1  byte request to memory controller
- mc_rw_o  out  1  1 write, 0 read
- mc_addr_o  out  32  byte address
- mc_wdata_o  out  8  write byte
- mc_rdata_i  in  8  read byte; valid in the cycle mc_done_i=1
- mc_done_i  in  1  one-cycle pulse per completed byte

Behaviour:
- Reset: state IDLE, byte counter 0, load buffer 0. All outputs read 0 while rst=1, including the combinational ones.
- N = number of bytes per access: byte 1, half 2, word 4.
- Byte k goes to address mem_me_addr_i+k, 32-bit wrap. Store byte k = mem_me_data_i[8k+7:8k]. No alignment check.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, op none:
  - wb_* = mem_*_i (combinational pass-through); stallreq_o=0; mc_req_o=0.
  - Zero added latency.
- IDLE, op load/store:
  - Same cycle: stallreq_o=1, wb_wreg_o=0.
  - Next edge: enter ACCESS, counter=0.
- ACCESS:
  - stallreq_o=1, wb_wreg_o=0, mc_req_o=1.
  - mc_rw_o = (op==store); mc_addr_o and mc_wdata_o are driven from the counter.
  - On mc_done_i: a load writes mc_rdata_i into buffer byte[counter]; counter increments, and address/data update at that edge.
  - If mc_done_i arrives with counter==N-1: go to DONE.
  - mc_req_o stays high between bytes. The controller must not sample the new byte until the cycle after done.
- DONE, exactly one cycle:
  - stallreq_o=0, mc_req_o=0.
  - Load: wb_wdata_o = buffer masked to N bytes, extended per mem_me_extend_i from bit 7 (byte) or bit 15 (half); wb_wd_o=mem_wd_i; wb_wreg_o=mem_wreg_i.
  - Store: wb_* pass through (mem_wreg_i is 0 for stores).
  - Next edge: IDLE. The inputs at that point belong to the next instruction, so an op present in DONE is never restarted.
- Inputs are held stable by the pipeline while stallreq_o=1. The block latches only the counter and the load buffer.
- Per-access latency = sum of controller byte latencies + 2 cycles (IDLE detect + DONE).
- mc_done_i outside ACCESS: ignored.
- rst asserted mid-ACCESS: immediately IDLE, mc_req_o=0, partial load data discarded, partial store not rolled back.
- Back-to-back memory ops: DONE→IDLE→ACCESS. Every access has at least one idle req-low cycle.

Test Plan:
- Op none, wdata=0x1234, wd=5, wreg=1 -> wb outputs equal inputs in the same cycle; stallreq_o never asserts; mc_req_o=0.
- Load word at 0x100, controller returns 0x78,0x56,0x34,0xF2 with done 2 cycles after each address -> addresses 0x100..0x103 in order; stallreq high until DONE; DONE cycle shows wb_wdata_o=0xF2345678 and wb_wreg_o=1.
- Load byte 0x80: sign-extend -> 0xFFFFFF80; zero-extend -> 0x00000080. Load half 0x8001 sign -> 0xFFFF8001.
- Store half 0xAABBCCDD at 0x2001 -> two writes, (0x2001, 0xDD) then (0x2002, 0xCC); mc_rw_o=1; wb_wreg_o=0 throughout.
- Store word then load byte back-to-back -> req drops for at least one cycle between them; the load returns the stored byte; no double execution of the store.
- rst pulse after the 2nd byte of a word load -> outputs 0 immediately; after release, state IDLE, no residual mc_req_o, and the next load assembles fresh data.
